// File: rtl/alu_issue_stage.sv
// Single-issue RV32I ALU front end: decodes one R/I-type instruction, drives an
// external ALU for one cycle, writes the register file and holds the result.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [31:0] alu_lhs,
    output logic [31:0] alu_rhs,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_res,
    input  logic [3:0]  alu_flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags,
    output logic        out_err,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WB    = 2'd2;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    logic [1:0]  r_state;
    logic [31:0] r_rf [32];
    logic [31:0] r_lhs;
    logic [31:0] r_rhs;
    logic [3:0]  r_op;
    logic [4:0]  r_rd;
    logic        r_err;
    logic        r_wen;
    logic [31:0] r_result;
    logic [3:0]  r_flags;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_funct7;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_imm;

    logic        w_legal;
    logic        w_alt;
    logic        w_shift;
    logic [31:0] w_rhs_raw;
    logic [4:0]  w_shamt;
    logic [3:0]  w_op;
    logic [31:0] w_lhs;
    logic [31:0] w_rhs;

    assign w_opcode  = in_instr[6:0];
    assign w_rd      = in_instr[11:7];
    assign w_funct3  = in_instr[14:12];
    assign w_rs1     = in_instr[19:15];
    assign w_rs2     = in_instr[24:20];
    assign w_funct7  = in_instr[31:25];
    assign w_imm     = {{20{in_instr[31]}}, in_instr[31:20]};
    // rf[0] is reset to zero and never written, so it reads as zero directly.
    assign w_rs1_val = r_rf[w_rs1];
    assign w_rs2_val = r_rf[w_rs2];

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_legal   = 1'b0;
        w_alt     = 1'b0;
        w_rhs_raw = 32'd0;
        w_shamt   = 5'd0;
        case (w_opcode)
            OPC_R: begin
                w_alt     = (w_funct7 == F7_ALT);
                w_legal   = (w_funct7 == 7'd0) ||
                            (w_alt && (w_funct3 == 3'b000 || w_funct3 == 3'b101));
                w_rhs_raw = w_rs2_val;
                w_shamt   = w_rs2_val[4:0];
            end
            OPC_I: begin
                // Only shift-immediates reuse instr[31:25] as a function field; addi has no alternate form.
                w_alt     = (w_funct3 == 3'b101) && (w_funct7 == F7_ALT);
                case (w_funct3)
                    3'b001:  w_legal = (w_funct7 == 7'd0);
                    3'b101:  w_legal = (w_funct7 == 7'd0) || (w_funct7 == F7_ALT);
                    default: w_legal = 1'b1;
                endcase
                w_rhs_raw = w_imm;
                w_shamt   = in_instr[24:20];
            end
            default: w_legal = 1'b0;
        endcase

        case (w_funct3)
            3'b000:  w_op = w_alt ? 4'b1000 : 4'b0000;
            3'b101:  w_op = w_alt ? 4'b1001 : 4'b0101;
            default: w_op = {1'b0, w_funct3};
        endcase
        w_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
        w_rhs   = w_shift ? {27'd0, w_shamt} : w_rhs_raw;
        w_lhs   = w_rs1_val;

        if (!w_legal) begin
            w_op  = 4'b0000;
            w_lhs = 32'd0;
            w_rhs = 32'd0;
        end
    end

    // NOTE: the register file is cleared by the asynchronous reset, which costs a reset
    // net on every storage bit but guarantees the all-zero state a debug read expects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
            r_lhs    <= 32'd0;
            r_rhs    <= 32'd0;
            r_op     <= 4'd0;
            r_rd     <= 5'd0;
            r_err    <= 1'b0;
            r_wen    <= 1'b0;
            r_result <= 32'd0;
            r_flags  <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_lhs   <= w_lhs;
                        r_rhs   <= w_rhs;
                        r_op    <= w_op;
                        r_rd    <= w_rd;
                        r_err   <= !w_legal;
                        r_wen   <= w_legal && (w_rd != 5'd0);
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_result <= r_err ? 32'd0 : alu_res;
                    r_flags  <= alu_flags;
                    if (r_wen) r_rf[r_rd] <= alu_res;
                    r_state  <= S_WB;
                end
                S_WB: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_WB);
    assign alu_lhs    = r_lhs;
    assign alu_rhs    = r_rhs;
    assign alu_op     = r_op;
    assign out_rd     = r_rd;
    assign out_result = r_result;
    assign out_flags  = r_flags;
    assign out_err    = r_err;
    assign dbg_data   = (dbg_addr == 5'd0) ? 32'd0 : r_rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed table, stall and reset
// sequences, then random instructions against an instruction-level model.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] alu_lhs;
    logic [31:0] alu_rhs;
    logic [3:0]  alu_op;
    logic [31:0] alu_res;
    logic [3:0]  alu_flags;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        out_err;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_op(alu_op),
        .alu_res(alu_res), .alu_flags(alu_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_result(out_result), .out_flags(out_flags), .out_err(out_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: evaluates the presented operands on every falling edge.
    logic [32:0] alu_t;
    logic        alu_c;
    logic        alu_v;
    always @(negedge clk) begin
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_op)
            4'd0: begin
                alu_t   = {1'b0, alu_lhs} + {1'b0, alu_rhs};
                alu_res = alu_t[31:0];
                alu_c   = alu_t[32];
                alu_v   = (alu_lhs[31] == alu_rhs[31]) && (alu_res[31] != alu_lhs[31]);
            end
            4'd8: begin
                alu_t   = {1'b0, alu_lhs} - {1'b0, alu_rhs};
                alu_res = alu_t[31:0];
                alu_c   = alu_t[32];
                alu_v   = (alu_lhs[31] != alu_rhs[31]) && (alu_res[31] != alu_lhs[31]);
            end
            4'd1: alu_res = alu_lhs << alu_rhs[4:0];
            4'd2: alu_res = ($signed(alu_lhs) < $signed(alu_rhs)) ? 32'd1 : 32'd0;
            4'd3: alu_res = (alu_lhs < alu_rhs) ? 32'd1 : 32'd0;
            4'd4: alu_res = alu_lhs ^ alu_rhs;
            4'd5: alu_res = alu_lhs >> alu_rhs[4:0];
            4'd9: alu_res = $signed(alu_lhs) >>> alu_rhs[4:0];
            4'd6: alu_res = alu_lhs | alu_rhs;
            4'd7: alu_res = alu_lhs & alu_rhs;
            default: alu_res = 32'd0;
        endcase
        alu_flags = {alu_res == 32'd0, alu_res[31], alu_c, alu_v};
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural register state as the instruction set defines it.
    logic [31:0] m_rf [32];

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic void model_exec(input logic [31:0] ins, output logic [31:0] res,
                                       output logic [3:0] fl, output logic err);
        logic [6:0]  opc = ins[6:0];
        logic [2:0]  f3  = ins[14:12];
        logic [6:0]  f7  = ins[31:25];
        logic [31:0] a   = m_rf[ins[19:15]];
        logic [31:0] b   = 32'd0;
        logic [4:0]  sh  = 5'd0;
        logic        legal = 1'b0;
        logic        alt   = 1'b0;
        logic        c = 1'b0;
        logic        v = 1'b0;
        longint      s;
        longint unsigned u;
        if (opc == 7'b0110011) begin
            b     = m_rf[ins[24:20]];
            sh    = b[4:0];
            alt   = f7[5];
            legal = (f7 == 7'd0) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        end else if (opc == 7'b0010011) begin
            b     = {{20{ins[31]}}, ins[31:20]};
            sh    = ins[24:20];
            alt   = (f3 == 3'd5) && f7[5];
            if (f3 == 3'd1)      legal = (f7 == 7'd0);
            else if (f3 == 3'd5) legal = (f7 == 7'd0) || (f7 == 7'h20);
            else                 legal = 1'b1;
        end
        res = 32'd0;
        case (f3)
            3'd0: begin
                if (alt) begin
                    res = a - b;
                    c   = (a < b);
                    s   = longint'($signed(a)) - longint'($signed(b));
                end else begin
                    res = a + b;
                    u   = longint'(a) + longint'(b);
                    c   = ((u >> 32) != 0);
                    s   = longint'($signed(a)) + longint'($signed(b));
                end
                v = (s > longint'(32'sh7FFFFFFF)) || (s < longint'(32'sh80000000));
            end
            3'd1: res = a << sh;
            3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd5: begin
                if (alt) res = $signed(a) >>> sh;
                else     res = a >> sh;
            end
            3'd6: res = a | b;
            default: res = a & b;
        endcase
        if (!legal) begin
            res = 32'd0;
            fl  = 4'b1000;
            err = 1'b1;
        end else begin
            fl  = {res == 32'd0, res[31], c, v};
            err = 1'b0;
            if (ins[11:7] != 5'd0) m_rf[ins[11:7]] = res;
        end
    endfunction

    task automatic dbg_check(input string name, input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        check(name, dbg_data, exp);
    endtask

    // Offers one instruction from IDLE, checks latency and the WB outputs, then retires it.
    task automatic run_instr(input string tag, input logic [31:0] ins, input logic [31:0] e_res,
                             input logic [3:0] e_fl, input logic e_err);
        int n;
        check({tag, " in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_instr = ins;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_instr = $urandom;
        n = 0;
        while (!out_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, n, 1);
        check({tag, " rd"}, out_rd, ins[11:7]);
        check({tag, " result"}, out_result, e_res);
        check({tag, " flags"}, out_flags, e_fl);
        check({tag, " err"}, out_err, e_err);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] res;
        logic [3:0]  flags;
        logic        err;
        logic [4:0]  dbg_reg;
        logic [31:0] dbg_val;
    } vec_t;

    vec_t        tbl [14];
    logic [31:0] m_res;
    logic [3:0]  m_fl;
    logic        m_err;
    logic [31:0] held;

    initial begin
        tbl[0]  = '{enc_i(12'd5, 5'd0, 3'd0, 5'd1),            32'd5,        4'b0000, 1'b0, 5'd1,  32'd5};
        tbl[1]  = '{enc_i(12'hFFD, 5'd0, 3'd0, 5'd2),          32'hFFFFFFFD, 4'b0100, 1'b0, 5'd2,  32'hFFFFFFFD};
        tbl[2]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3),      32'd2,        4'b0010, 1'b0, 5'd3,  32'd2};
        tbl[3]  = '{enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4),      32'hFFFFFFF8, 4'b0100, 1'b0, 5'd4,  32'hFFFFFFF8};
        tbl[4]  = '{enc_i(12'd1, 5'd0, 3'd0, 5'd5),            32'd1,        4'b0000, 1'b0, 5'd5,  32'd1};
        tbl[5]  = '{enc_i({7'h00, 5'd31}, 5'd5, 3'd1, 5'd5),   32'h80000000, 4'b0100, 1'b0, 5'd5,  32'h80000000};
        tbl[6]  = '{enc_i({7'h20, 5'd4}, 5'd5, 3'd5, 5'd6),    32'hF8000000, 4'b0100, 1'b0, 5'd6,  32'hF8000000};
        tbl[7]  = '{enc_i({7'h00, 5'd4}, 5'd5, 3'd5, 5'd6),    32'h08000000, 4'b0000, 1'b0, 5'd6,  32'h08000000};
        tbl[8]  = '{enc_i(12'd33, 5'd0, 3'd0, 5'd9),           32'd33,       4'b0000, 1'b0, 5'd9,  32'd33};
        tbl[9]  = '{enc_r(7'h00, 5'd9, 5'd1, 3'd1, 5'd10),     32'd10,       4'b0000, 1'b0, 5'd10, 32'd10};
        tbl[10] = '{enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd7),      32'd1,        4'b0000, 1'b0, 5'd7,  32'd1};
        tbl[11] = '{enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd7),      32'd0,        4'b1000, 1'b0, 5'd7,  32'd0};
        tbl[12] = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0),      32'd2,        4'b0010, 1'b0, 5'd0,  32'd0};
        tbl[13] = '{{12'd4, 5'd1, 3'd2, 5'd11, 7'b0000011},    32'd0,        4'b1000, 1'b1, 5'd11, 32'd0};

        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0; dbg_addr = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst alu_lhs", alu_lhs, 0);
        check("rst alu_rhs", alu_rhs, 0);
        check("rst alu_op", alu_op, 0);
        check("rst out_result", out_result, 0);
        check("rst out_flags", out_flags, 0);
        check("rst out_rd", out_rd, 0);
        check("rst out_err", out_err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-rst in_ready", in_ready, 1);

        for (int i = 0; i < 14; i++) begin
            run_instr($sformatf("vec%0d", i), tbl[i].instr, tbl[i].res, tbl[i].flags, tbl[i].err);
            dbg_check($sformatf("vec%0d dbg", i), tbl[i].dbg_reg, tbl[i].dbg_val);
            model_exec(tbl[i].instr, m_res, m_fl, m_err);
        end
        for (int r = 0; r < 32; r++) dbg_check($sformatf("table rf x%0d", r), 5'(r), m_rf[r]);

        // Result held under back-pressure; a second offer during WB is ignored.
        check("stall in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_instr = {12'd0, 5'd2, 3'd0, 5'd12, 7'b0000011};
        @(posedge clk); #1;
        in_instr = enc_i(12'd1, 5'd0, 3'd0, 5'd12);
        @(posedge clk); #1;
        held = out_result;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall%0d out_valid", c), out_valid, 1);
            check($sformatf("stall%0d in_ready", c), in_ready, 0);
            check($sformatf("stall%0d out_err", c), out_err, 1);
            check($sformatf("stall%0d out_result", c), out_result, 32'd0);
            check($sformatf("stall%0d out_rd", c), out_rd, 5'd12);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stall release in_ready", in_ready, 1);
        check("stall release out_valid", out_valid, 0);
        dbg_check("stall x12 untouched", 5'd12, 32'd0);

        for (int k = 0; k < 150; k++) begin
            logic [31:0] ins;
            logic [2:0]  f3;
            logic [6:0]  f7;
            int          kind, pick;
            kind = $urandom_range(0, 9);
            f3   = 3'($urandom_range(0, 7));
            pick = $urandom_range(0, 9);
            f7   = (pick < 6) ? 7'h00 : (pick < 9) ? 7'h20 : 7'($urandom);
            if (kind < 4) begin
                ins = enc_r(f7, 5'($urandom), 5'($urandom), f3, 5'($urandom));
            end else if (kind < 8) begin
                ins = enc_i(12'($urandom), 5'($urandom), f3, 5'($urandom));
                if (f3 == 3'd1 || f3 == 3'd5) ins[31:25] = f7;
            end else if (kind == 8) begin
                ins = $urandom;
                if (ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0010011) ins[6:0] = 7'b1111111;
            end else begin
                ins = enc_i(12'($urandom_range(0, 64)), 5'd0, 3'd0, 5'($urandom_range(1, 31)));
            end
            model_exec(ins, m_res, m_fl, m_err);
            run_instr($sformatf("rnd%0d %h", k, ins), ins, m_res, m_fl, m_err);
        end
        for (int r = 0; r < 32; r++) dbg_check($sformatf("rnd rf x%0d", r), 5'(r), m_rf[r]);

        // Reset pulse during ISSUE aborts the instruction and clears the register file.
        check("abort in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_instr = enc_i(12'd7, 5'd0, 3'd0, 5'd8);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abort in ISSUE", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("abort async idle", in_ready, 1);
        check("abort out_valid", out_valid, 0);
        check("abort alu_op", alu_op, 0);
        check("abort alu_lhs", alu_lhs, 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check($sformatf("abort cyc%0d out_valid", c), out_valid, 0);
            check($sformatf("abort cyc%0d in_ready", c), in_ready, 1);
        end
        for (int r = 0; r < 32; r++) dbg_check($sformatf("abort rf x%0d", r), 5'(r), 32'd0);

        run_instr("post-abort addi", enc_i(12'd9, 5'd0, 3'd0, 5'd1), 32'd9, 4'b0000, 1'b0);
        dbg_check("post-abort x1", 5'd1, 32'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
